// File: rtl/accumulator_ctrl_pkg.sv
// accumulator_ctrl_pkg
//   Shared types and encodings for the accumulator control unit:
//   - state_e   : 4-bit FSM state enum (value is what state_o shows)
//   - OP_*      : instruction opcodes (IR[15:12])
//   - *_sel     : mux select encodings driven towards the datapath
//   - ctrl_t    : bundle of control outputs produced by the decoder
package accumulator_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_RD   = 4'd3,
    S_ALU_EX   = 4'd4,
    S_ADDI_EX  = 4'd5,
    S_LOAD_WB  = 4'd6,
    S_STORE_EX = 4'd7,
    S_BR_EX    = 4'd8,
    S_JMP_EX   = 4'd9,
    S_PUSH1    = 4'd10,
    S_PUSH2    = 4'd11,
    S_POP1     = 4'd12,
    S_POP2     = 4'd13,
    S_POP3     = 4'd14,
    S_HALT     = 4'd15
  } state_e;

  // Opcodes
  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_ADDI  = 4'h4;
  localparam logic [3:0] OP_LOAD  = 4'h5;
  localparam logic [3:0] OP_STORE = 4'h6;
  localparam logic [3:0] OP_BEQ   = 4'h7;
  localparam logic [3:0] OP_BNE   = 4'h8;
  localparam logic [3:0] OP_JUMP  = 4'h9;
  localparam logic [3:0] OP_PUSH  = 4'hA;
  localparam logic [3:0] OP_POP   = 4'hB;
  localparam logic [3:0] OP_HALT  = 4'hF;

  // PCSrc
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ZE     = 2'd1;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd2;

  // MemAddr
  localparam logic [1:0] MA_PC     = 2'd0;
  localparam logic [1:0] MA_ZE     = 2'd1;
  localparam logic [1:0] MA_ALUOUT = 2'd2;
  localparam logic [1:0] MA_SP     = 2'd3;

  // MemData
  localparam logic MD_ACC    = 1'b0;
  localparam logic MD_ALUOUT = 1'b1;

  // ALUSrcA
  localparam logic [1:0] SA_PC  = 2'd0;
  localparam logic [1:0] SA_ACC = 2'd1;
  localparam logic [1:0] SA_SP  = 2'd2;

  // ALUSrcB
  localparam logic [2:0] SB_MDR  = 3'd0;
  localparam logic [2:0] SB_TWO  = 3'd1;
  localparam logic [2:0] SB_SE   = 3'd2;
  localparam logic [2:0] SB_ZE   = 3'd3;
  localparam logic [2:0] SB_SL1  = 3'd4;
  localparam logic [2:0] SB_ZERO = 3'd5;

  // ALUOp
  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_AND   = 3'd2;
  localparam logic [2:0] ALU_OR    = 3'd3;
  localparam logic [2:0] ALU_PASSB = 3'd4;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic       bne_or_beq;
    logic [1:0] pc_src;
    logic [1:0] mem_addr;
    logic       mem_data;
    logic       mem_write;
    logic       acc_write;
    logic       sp_write;
    logic [1:0] alu_src_a;
    logic [2:0] alu_src_b;
    logic [2:0] alu_op;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/accumulator_ctrl_decode.sv
// accumulator_ctrl_decode
//   Purely combinational map from (current state, opcode) to the control
//   bundle. Anything a state does not mention stays 0.
//   Ports:
//     state_i  : current FSM state
//     opcode_i : IR opcode field
//     ctrl_o   : control outputs towards the datapath
module accumulator_ctrl_decode
  import accumulator_ctrl_pkg::*;
(
  input  state_e     state_i,
  input  logic [3:0] opcode_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_addr  = MA_PC;
        ctrl_o.ir_write  = 1'b1;
        ctrl_o.alu_src_a = SA_PC;
        ctrl_o.alu_src_b = SB_TWO;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.pc_src    = PCSRC_ALU;
        ctrl_o.pc_write  = 1'b1;
      end
      S_DECODE: begin
        // MDR picks up mem[ZE]; aluOut captures the branch target PC+SL1.
        ctrl_o.mem_addr  = MA_ZE;
        ctrl_o.alu_src_a = SA_PC;
        ctrl_o.alu_src_b = SB_SL1;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEM_RD: ctrl_o.mem_addr = MA_ZE;
      S_ALU_EX: begin
        // Opcodes 0..3 line up with ALU ADD/SUB/AND/OR.
        ctrl_o.alu_src_a = SA_ACC;
        ctrl_o.alu_src_b = SB_MDR;
        ctrl_o.alu_op    = {1'b0, opcode_i[1:0]};
        ctrl_o.acc_write = 1'b1;
      end
      S_ADDI_EX: begin
        ctrl_o.alu_src_a = SA_ACC;
        ctrl_o.alu_src_b = SB_SE;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.acc_write = 1'b1;
      end
      S_LOAD_WB: begin
        ctrl_o.alu_src_b = SB_MDR;
        ctrl_o.alu_op    = ALU_PASSB;
        ctrl_o.acc_write = 1'b1;
      end
      S_STORE_EX: begin
        ctrl_o.mem_addr  = MA_ZE;
        ctrl_o.mem_data  = MD_ACC;
        ctrl_o.mem_write = 1'b1;
      end
      S_BR_EX: begin
        // ACC - 0 drives the zero flag that qualifies Branch.
        ctrl_o.alu_src_a  = SA_ACC;
        ctrl_o.alu_src_b  = SB_ZERO;
        ctrl_o.alu_op     = ALU_SUB;
        ctrl_o.branch     = 1'b1;
        ctrl_o.bne_or_beq = (opcode_i == OP_BNE);
        ctrl_o.pc_src     = PCSRC_ALUOUT;
      end
      S_JMP_EX: begin
        ctrl_o.pc_src   = PCSRC_ZE;
        ctrl_o.pc_write = 1'b1;
      end
      S_PUSH1: begin
        ctrl_o.alu_src_a = SA_SP;
        ctrl_o.alu_src_b = SB_TWO;
        ctrl_o.alu_op    = ALU_SUB;
        ctrl_o.sp_write  = 1'b1;
      end
      S_PUSH2: begin
        ctrl_o.mem_addr  = MA_SP;
        ctrl_o.mem_data  = MD_ACC;
        ctrl_o.mem_write = 1'b1;
      end
      S_POP1: ctrl_o.mem_addr = MA_SP;
      S_POP2: begin
        ctrl_o.alu_src_b = SB_MDR;
        ctrl_o.alu_op    = ALU_PASSB;
        ctrl_o.acc_write = 1'b1;
      end
      S_POP3: begin
        ctrl_o.alu_src_a = SA_SP;
        ctrl_o.alu_src_b = SB_TWO;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.sp_write  = 1'b1;
      end
      S_HALT:  ctrl_o.halted = 1'b1;
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/accumulator_control.sv
// accumulator_control
//   Multicycle Moore control unit for the 16-bit accumulator datapath.
//   Holds the FSM state register and sticky illegal flag; all control
//   outputs are decoded from (state, IR opcode) by accumulator_ctrl_decode.
//   Ports:
//     CLK, reset            : clock (rising edge), synchronous active-high reset
//     IR                    : current instruction register
//     IRWrite..ALUOp        : datapath controls (see package encodings)
//     state_o               : current state (debug)
//     halted                : high while in HALT
//     illegal               : sticky, set when an illegal opcode is decoded
module accumulator_control
  import accumulator_ctrl_pkg::*;
#(
  parameter int OPC_MSB = 15,
  parameter int OPC_W   = 4
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [15:0] IR,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        Branch,
  output logic        bneOrbeq,
  output logic [1:0]  PCSrc,
  output logic [1:0]  MemAddr,
  output logic        MemData,
  output logic        MemWrite,
  output logic        AccWrite,
  output logic        SpWrite,
  output logic [1:0]  ALUSrcA,
  output logic [2:0]  ALUSrcB,
  output logic [2:0]  ALUOp,
  output logic [3:0]  state_o,
  output logic        halted,
  output logic        illegal
);

  state_e           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [OPC_W-1:0] opcode;
  ctrl_t            ctrl;

  assign opcode = IR[OPC_MSB -: OPC_W];

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LOAD: state_d = S_MEM_RD;
          OP_ADDI:        state_d = S_ADDI_EX;
          OP_STORE:       state_d = S_STORE_EX;
          OP_BEQ, OP_BNE: state_d = S_BR_EX;
          OP_JUMP:        state_d = S_JMP_EX;
          OP_PUSH:        state_d = S_PUSH1;
          OP_POP:         state_d = S_POP1;
          OP_HALT:        state_d = S_HALT;
          default: begin
            // C, D, E: stop the machine and flag it.
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEM_RD: state_d = (opcode == OP_LOAD) ? S_LOAD_WB : S_ALU_EX;
      S_PUSH1:  state_d = S_PUSH2;
      S_POP1:   state_d = S_POP2;
      S_POP2:   state_d = S_POP3;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  accumulator_ctrl_decode u_decode (
    .state_i  (state_q),
    .opcode_i (opcode),
    .ctrl_o   (ctrl)
  );

  assign IRWrite  = ctrl.ir_write;
  assign PCWrite  = ctrl.pc_write;
  assign Branch   = ctrl.branch;
  assign bneOrbeq = ctrl.bne_or_beq;
  assign PCSrc    = ctrl.pc_src;
  assign MemAddr  = ctrl.mem_addr;
  assign MemData  = ctrl.mem_data;
  assign MemWrite = ctrl.mem_write;
  assign AccWrite = ctrl.acc_write;
  assign SpWrite  = ctrl.sp_write;
  assign ALUSrcA  = ctrl.alu_src_a;
  assign ALUSrcB  = ctrl.alu_src_b;
  assign ALUOp    = ctrl.alu_op;
  assign halted   = ctrl.halted;
  assign illegal  = illegal_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_accumulator_control.sv
// tb_accumulator_control
//   Directed + randomized bench. Each instruction is expanded by a
//   per-instruction script into the expected per-cycle sequence of
//   (state, control word); the scoreboard pops one entry per cycle.
module tb_accumulator_control;
  import accumulator_ctrl_pkg::*;

  // Expected control word, literal encodings from the interface table.
  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic       bne;
    logic [1:0] pc_src;
    logic [1:0] mem_addr;
    logic       mem_data;
    logic       mem_write;
    logic       acc_write;
    logic       sp_write;
    logic [1:0] src_a;
    logic [2:0] src_b;
    logic [2:0] alu_op;
    logic       halted;
    logic       illegal;
  } exp_t;

  localparam int W = 4 + $bits(exp_t);

  // ---------------- clock / reset ----------------
  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] IR = 16'h0000;
  logic        IRWrite, PCWrite, Branch, bneOrbeq, MemData, MemWrite;
  logic        AccWrite, SpWrite, halted, illegal;
  logic [1:0]  PCSrc, MemAddr, ALUSrcA;
  logic [2:0]  ALUSrcB, ALUOp;
  logic [3:0]  state_o;

  always #5 CLK = ~CLK;

  accumulator_control dut (
    .CLK(CLK), .reset(reset), .IR(IR),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .Branch(Branch), .bneOrbeq(bneOrbeq),
    .PCSrc(PCSrc), .MemAddr(MemAddr), .MemData(MemData), .MemWrite(MemWrite),
    .AccWrite(AccWrite), .SpWrite(SpWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .state_o(state_o), .halted(halted), .illegal(illegal)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_vec  = 0;
  int n_fail = 0;
  logic illegal_exp = 1'b0;

  function automatic exp_t observed();
    exp_t o;
    o = '{ir_write: IRWrite, pc_write: PCWrite, branch: Branch, bne: bneOrbeq,
          pc_src: PCSrc, mem_addr: MemAddr, mem_data: MemData,
          mem_write: MemWrite, acc_write: AccWrite, sp_write: SpWrite,
          src_a: ALUSrcA, src_b: ALUSrcB, alu_op: ALUOp, halted: halted,
          illegal: illegal};
    return o;
  endfunction

  function automatic exp_t zero_word();
    exp_t c;
    c = '0;
    c.illegal = illegal_exp;
    return c;
  endfunction

  task automatic push_step(input logic [3:0] st, input exp_t c);
    exp_q.push_back({st, c});
  endtask

  // Expected cycle script for one instruction, FETCH through last step.
  task automatic expect_instr(input logic [3:0] opc);
    exp_t c;
    c = zero_word(); c.ir_write = 1; c.pc_write = 1; c.src_b = 3'd1;
    push_step(4'(S_FETCH), c);
    c = zero_word(); c.mem_addr = 2'd1; c.src_b = 3'd4;
    push_step(4'(S_DECODE), c);
    case (opc)
      4'h0, 4'h1, 4'h2, 4'h3: begin
        c = zero_word(); c.mem_addr = 2'd1; push_step(4'(S_MEM_RD), c);
        c = zero_word(); c.src_a = 2'd1; c.src_b = 3'd0;
        c.alu_op = 3'(opc); c.acc_write = 1;
        push_step(4'(S_ALU_EX), c);
      end
      4'h4: begin
        c = zero_word(); c.src_a = 2'd1; c.src_b = 3'd2; c.acc_write = 1;
        push_step(4'(S_ADDI_EX), c);
      end
      4'h5: begin
        c = zero_word(); c.mem_addr = 2'd1; push_step(4'(S_MEM_RD), c);
        c = zero_word(); c.alu_op = 3'd4; c.acc_write = 1;
        push_step(4'(S_LOAD_WB), c);
      end
      4'h6: begin
        c = zero_word(); c.mem_addr = 2'd1; c.mem_write = 1;
        push_step(4'(S_STORE_EX), c);
      end
      4'h7, 4'h8: begin
        c = zero_word(); c.src_a = 2'd1; c.src_b = 3'd5; c.alu_op = 3'd1;
        c.branch = 1; c.bne = (opc == 4'h8); c.pc_src = 2'd2;
        push_step(4'(S_BR_EX), c);
      end
      4'h9: begin
        c = zero_word(); c.pc_src = 2'd1; c.pc_write = 1;
        push_step(4'(S_JMP_EX), c);
      end
      4'hA: begin
        c = zero_word(); c.src_a = 2'd2; c.src_b = 3'd1; c.alu_op = 3'd1;
        c.sp_write = 1; push_step(4'(S_PUSH1), c);
        c = zero_word(); c.mem_addr = 2'd3; c.mem_write = 1;
        push_step(4'(S_PUSH2), c);
      end
      4'hB: begin
        c = zero_word(); c.mem_addr = 2'd3; push_step(4'(S_POP1), c);
        c = zero_word(); c.alu_op = 3'd4; c.acc_write = 1;
        push_step(4'(S_POP2), c);
        c = zero_word(); c.src_a = 2'd2; c.src_b = 3'd1; c.sp_write = 1;
        push_step(4'(S_POP3), c);
      end
      4'hF: begin
        c = zero_word(); c.halted = 1; push_step(4'(S_HALT), c);
      end
      default: begin
        illegal_exp = 1'b1;
        c = zero_word(); c.halted = 1; push_step(4'(S_HALT), c);
      end
    endcase
  endtask

  // One cycle: wait to the falling edge, compare against queue head.
  task automatic check_next();
    logic [W-1:0] w;
    logic [3:0]   st;
    exp_t         e, o;
    w  = exp_q.pop_front();
    st = w[W-1 -: 4];
    e  = exp_t'(w[W-5:0]);
    @(negedge CLK);
    o = observed();
    n_vec++;
    assert (state_o === st) else begin
      n_fail++;
      $error("FAIL state: observed %0d expected %0d (IR=%h)", state_o, st, IR);
    end
    n_vec++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL ctl st=%0d: observed %h expected %h (IR=%h)", st, o, e, IR);
    end
    n_vec++;
    assert (!(PCWrite && Branch) && !(MemWrite && IRWrite)) else begin
      n_fail++;
      $error("FAIL excl st=%0d: observed pcw=%b br=%b mw=%b irw=%b expected no overlap",
             st, PCWrite, Branch, MemWrite, IRWrite);
    end
  endtask

  task automatic run_all();
    while (exp_q.size() > 0) check_next();
  endtask

  // Set IR (state is idle or on the last step of the previous instruction)
  // and walk the full instruction.
  task automatic run_instr(input logic [15:0] ir);
    IR = ir;
    expect_instr(ir[15:12]);
    run_all();
  endtask

  task automatic dwell_halt(input int cycles);
    exp_t c;
    for (int i = 0; i < cycles; i++) begin
      c = zero_word(); c.halted = 1; push_step(4'(S_HALT), c);
    end
    run_all();
  endtask

  // Hold reset for the given number of cycles, then check IDLE is all zero.
  task automatic do_reset(input int cycles);
    reset = 1'b1;
    illegal_exp = 1'b0;
    repeat (cycles - 1) @(negedge CLK);
    push_step(4'(S_IDLE), zero_word());
    run_all();
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] opc;
    do_reset(2);

    // Directed
    run_instr(16'h0005);   // ADD
    run_instr(16'h8010);   // BNE
    run_instr(16'h7010);   // BEQ
    run_instr(16'hA000);   // PUSH
    run_instr(16'hB000);   // POP
    run_instr(16'h4FFF);   // ADDI
    run_instr(16'h5123);   // LOAD
    run_instr(16'h6123);   // STORE
    run_instr(16'h9ABC);   // JUMP

    // Randomized legal instruction stream
    repeat (60) begin
      opc = 4'($urandom_range(0, 11));
      run_instr({opc, 12'($urandom)});
    end

    // Reset while in PUSH1: must land in IDLE with no strobes, then a
    // normal instruction must follow with no stray MemWrite.
    IR = 16'hA000;
    expect_instr(4'hA);
    check_next();          // FETCH
    check_next();          // DECODE
    check_next();          // PUSH1
    exp_q.delete();
    do_reset(1);
    run_instr(16'h1234);   // SUB

    // HALT opcode: halts, illegal stays clear
    run_instr(16'hF000);
    dwell_halt(12);
    do_reset(1);

    // Illegal opcode: halts with sticky illegal, reset clears it
    run_instr(16'hC123);
    dwell_halt(12);
    do_reset(1);
    run_instr(16'hD000);
    dwell_halt(3);
    do_reset(1);
    run_instr(16'h3777);   // OR after recovery

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/accumulator_control.md
Name: accumulator_control

Overview:
- Multicycle control unit for the 16-bit accumulator datapath. It is the other end of the control interface that the datapath top level consumes.
- Sequences each instruction through a Moore FSM and drives PCWrite, Branch, bneOrbeq, PCSrc, MemAddr, MemData, MemWrite, AccWrite, SpWrite, ALUSrcA, ALUSrcB, ALUOp and IRWrite from the current state and the IR opcode.
- Sits beside the datapath; the IR comes from the memory subsystem.

Parameters:
- OPC_MSB, 15, top bit of the opcode field in IR.
- OPC_W, 4, opcode width; the opcode is IR[OPC_MSB -: OPC_W].

Ports:
- CLK  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- IR  in  16  current instruction register
- IRWrite  out  1  latch memory data into IR
- PCWrite  out  1  unconditional PC write
- Branch  out  1  conditional PC write, qualified by zero
- bneOrbeq  out  1  0 = BEQ (write when zero), 1 = BNE (write when not zero)
- PCSrc  out  2  0 aluResult, 1 ZE, 2 aluOut
- MemAddr  out  2  0 PC, 1 ZE, 2 aluOut, 3 SP
- MemData  out  1  0 ACC, 1 aluOut
- MemWrite  out  1  memory write strobe
- AccWrite  out  1  ACC <= aluResult
- SpWrite  out  1  SP <= aluResult
- ALUSrcA  out  2  0 PC, 1 ACC, 2 SP
- ALUSrcB  out  3  0 MDR, 1 const 2, 2 SE, 3 ZE, 4 SL1, 5 const 0
- ALUOp  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 PASSB
- state_o  out  4  current state, debug only
- halted  out  1  high in HALT
- illegal  out  1  sticky; set when an illegal opcode is decoded

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high on the port named reset.
- Reset: at the next CLK edge, state <= IDLE and illegal <= 0.
- In IDLE every output is 0, including halted and illegal. IDLE goes to FETCH unconditionally.
- Output model: all outputs are a combinational decode of the state register and IR opcode (Moore-plus-opcode). Any signal not listed for a state is 0.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR: ACC op mem[ZE]
  - 4 ADDI: ACC + SE
  - 5 LOAD, 6 STORE
  - 7 BEQ, 8 BNE: test ACC == 0, target PC + SL1
  - 9 JUMP: PC <= ZE
  - A PUSH, B POP
  - F HALT
  - C, D, E illegal
- States and actions:
  - FETCH: MemAddr=0, IRWrite=1, ALUSrcA=0, ALUSrcB=1, ALUOp=ADD, PCSrc=0, PCWrite=1. Next state DECODE.
  - DECODE: MemAddr=1 (MDR loads mem[ZE]), ALUSrcA=0, ALUSrcB=4, ALUOp=ADD (aluOut = branch target). Next state by opcode.
  - MEM_RD: MemAddr=1. Goes to ALU_EX for opcodes 0-3, LOAD_WB for opcode 5.
  - ALU_EX: ALUSrcA=1, ALUSrcB=0, ALUOp=opcode[1:0], AccWrite=1. Next state FETCH.
  - ADDI_EX: ALUSrcA=1, ALUSrcB=2, ADD, AccWrite=1. Next state FETCH.
  - LOAD_WB: ALUSrcB=0, PASSB, AccWrite=1. Next state FETCH.
  - STORE_EX: MemAddr=1, MemData=0, MemWrite=1. Next state FETCH.
  - BR_EX: ALUSrcA=1, ALUSrcB=5, SUB, Branch=1, bneOrbeq=(opcode==8), PCSrc=2. Next state FETCH.
  - JMP_EX: PCSrc=1, PCWrite=1. Next state FETCH.
  - PUSH1: ALUSrcA=2, ALUSrcB=1, SUB, SpWrite=1.
  - PUSH2: MemAddr=3, MemData=0, MemWrite=1. Next state FETCH.
  - POP1: MemAddr=3.
  - POP2: ALUSrcB=0, PASSB, AccWrite=1.
  - POP3: ALUSrcA=2, ALUSrcB=1, ADD, SpWrite=1. Next state FETCH.
  - HALT: halted=1, all strobes 0. Absorbing until reset.
- Cycles per instruction (FETCH to FETCH):
  - ALU ops 4, ADDI 3, LOAD 4, STORE 3
  - BEQ/BNE 3, JUMP 3, PUSH 4, POP 5
  - HALT entered after 2 cycles
- Illegal opcode in DECODE: next state HALT, illegal <= 1. illegal stays set until reset.
- Mutual exclusion: PCWrite and Branch are never both 1. MemWrite and IRWrite are never both 1.
- Reset mid-instruction: takes priority over every transition. No write strobe is asserted in the reset cycle's following state (IDLE).
- state_o encodes the state enum value.

Decomposition:
- accumulator_ctrl_pkg holds:
  - state enum (4 bits)
  - opcode constants
  - PCSrc, MemAddr, ALUSrcA, ALUSrcB and ALUOp select encodings
- accumulator_ctrl_decode: a single combinational sub-module mapping (state, opcode) to control outputs.
- The FSM register and next-state logic stay in the top.

Test Plan:
- Reset held 2 cycles, then released -> all outputs 0 in IDLE, then FETCH with IRWrite=1, PCWrite=1, ALUSrcB=1.
- IR=16'h0005 (ADD) -> states FETCH, DECODE, MEM_RD, ALU_EX; AccWrite=1 only in ALU_EX with ALUOp=0, ALUSrcB=0; back in FETCH on cycle 5.
- IR=16'h8010 (BNE) -> BR_EX has Branch=1, bneOrbeq=1, PCSrc=2, PCWrite=0, ALUOp=SUB, ALUSrcB=5; with IR=16'h7010 (BEQ), bneOrbeq=0.
- IR=16'hA000 then 16'hB000 (PUSH, POP) -> SpWrite SUB in PUSH1, MemWrite with MemAddr=3 in PUSH2; POP takes 5 cycles, AccWrite in POP2, SpWrite ADD in POP3.
- IR=16'hC123 (illegal) -> HALT after DECODE, halted=1, illegal=1, no strobes for 10+ cycles; reset -> illegal=0, state IDLE.
- Reset asserted in PUSH1 -> next state IDLE; MemWrite never asserted afterwards until a new FETCH/DECODE of a store-type opcode.
